// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and
// the 18-bit instruction word layout.
package alu_cmd_sequencer_pkg;

  localparam int INSTR_W = 18;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  // Opcode occupies the MSBs, operand B the LSBs.
  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } instr_t;

endpackage

// File: rtl/alu_cmd_sequencer_alu8bit.sv
// Combinational 8-bit ALU: ADD with signed overflow and carry, signed 8x8
// multiply split across X (high byte) and Y (low byte), bitwise AND and XOR.
module alu8bit
  import alu_cmd_sequencer_pkg::*;
(
  input  logic [1:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       ovf,
  output logic       carry
);

  logic [8:0]         sum;
  logic signed [15:0] prod;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign prod = $signed(a) * $signed(b);

  always_comb begin
    x     = '0;
    y     = '0;
    ovf   = 1'b0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        x     = sum[7:0];
        carry = sum[8];
        ovf   = (a[7] == b[7]) && (sum[7] != a[7]);
      end
      OP_MUL:  {x, y} = prod;
      OP_AND:  x = a & b;
      OP_XOR:  x = a ^ b;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands in a small FIFO and runs each through a four-state
// issue/capture/hold sequence, presenting tagged results on a response port.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_x,
  output logic [7:0] rsp_y,
  output logic       rsp_ovf,
  output logic       rsp_carry,
  output logic [1:0] rsp_tag,
  output logic [7:0] ovf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  state_e             state_q, state_d;
  instr_t             mem_q [DEPTH];
  instr_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  instr_t             instr_q, instr_d;
  logic               ready_en_q, ready_en_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_x_q, rsp_x_d, rsp_y_q, rsp_y_d;
  logic               rsp_ovf_q, rsp_ovf_d, rsp_carry_q, rsp_carry_d;
  logic [1:0]         rsp_tag_q, rsp_tag_d, tag_q, tag_d;
  logic [7:0]         ovf_count_q, ovf_count_d;
  logic               push, pop, capture, release_rsp;
  logic [7:0]         alu_x, alu_y;
  logic               alu_ovf, alu_carry;

  alu8bit u_alu (
    .op    (instr_q.op),
    .a     (instr_q.a),
    .b     (instr_q.b),
    .x     (alu_x),
    .y     (alu_y),
    .ovf   (alu_ovf),
    .carry (alu_carry)
  );

  // ready_en_q keeps cmd_ready low until the first edge after reset release.
  assign cmd_ready = ready_en_q && (count_q != FULL_CNT) && !flush;
  assign push      = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (count_q != '0) state_d = ST_ISSUE;
        ST_ISSUE:   state_d = ST_CAPTURE;
        ST_CAPTURE: state_d = ST_HOLD;
        ST_HOLD:    if (rsp_ready) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pop         = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    if (!flush) begin
      case (state_q)
        ST_IDLE:    pop = (count_q != '0);
        ST_CAPTURE: capture = 1'b1;
        ST_HOLD:    release_rsp = rsp_ready;
        default:    ;
      endcase
    end
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    instr_d    = instr_q;
    ready_en_d = 1'b1;
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_op, cmd_a, cmd_b};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      instr_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Tag counter and ovf_count survive a flush; only the pending response is dropped.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_x_d     = rsp_x_q;
    rsp_y_d     = rsp_y_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_carry_d = rsp_carry_q;
    rsp_tag_d   = rsp_tag_q;
    tag_d       = tag_q;
    ovf_count_d = ovf_count_q;
    if (capture) begin
      rsp_valid_d = 1'b1;
      rsp_x_d     = alu_x;
      rsp_y_d     = alu_y;
      rsp_ovf_d   = alu_ovf;
      rsp_carry_d = alu_carry;
      rsp_tag_d   = tag_q;
      tag_d       = tag_q + 2'd1;
      if (alu_ovf && (ovf_count_q != 8'hFF)) ovf_count_d = ovf_count_q + 8'd1;
    end
    if (release_rsp || flush) rsp_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      instr_q     <= '0;
      ready_en_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_x_q     <= '0;
      rsp_y_q     <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_carry_q <= 1'b0;
      rsp_tag_q   <= '0;
      tag_q       <= '0;
      ovf_count_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      instr_q     <= instr_d;
      ready_en_q  <= ready_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_x_q     <= rsp_x_d;
      rsp_y_q     <= rsp_y_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_tag_q   <= rsp_tag_d;
      tag_q       <= tag_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_x     = rsp_x_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_tag   = rsp_tag_q;
  assign ovf_count = ovf_count_q;

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, 4, command FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  synchronous clear of FIFO, FSM and pending response.
REQ-005 SHALL have ports cmd_valid/cmd_ready  input/output  1/1  command handshake.
REQ-006 SHALL have ports cmd_op, cmd_a, cmd_b  input  2, 8, 8  opcode (00 ADD, 01 MUL, 10 AND, 11 XOR) and signed operands.
REQ-007 SHALL have ports rsp_valid/rsp_ready  output/input  1/1  response handshake.
REQ-008 SHALL have ports rsp_x, rsp_y  output  8, 8  captured ALU X and Y.
REQ-009 SHALL have ports rsp_ovf, rsp_carry  output  1, 1  captured ALU Overflow and Carry.
REQ-010 SHALL have port rsp_tag  output  2  issue sequence number of the response.
REQ-011 SHALL have port ovf_count  output  8  saturating count of responses with rsp_ovf=1.

Function
REQ-012 SHALL accept a command on an edge where cmd_valid && cmd_ready; cmd_ready = FIFO not full, and flush deasserted.
REQ-013 SHALL store {cmd_op, cmd_a, cmd_b} as one 18-bit instruction word in that bit order (op MSBs).
REQ-014 SHALL run FSM IDLE -> ISSUE -> CAPTURE -> HOLD -> IDLE.
REQ-015 IDLE: if FIFO non-empty, pop head into instr_q, go ISSUE; else stay.
REQ-016 ISSUE: instr_q drives the ALU for one full cycle; go CAPTURE.
REQ-017 CAPTURE: register ALU X, Y, Overflow, Carry and the tag counter into rsp_*; set rsp_valid; increment tag counter (2-bit wrap 3 -> 0); go HOLD.
REQ-018 HOLD: hold all rsp_* stable while rsp_valid && !rsp_ready; on rsp_ready clear rsp_valid, go IDLE.
REQ-019 Latency: command accepted into empty FIFO with FSM in IDLE at edge N -> rsp_valid high after edge N+3.
REQ-020 Throughput: at most one response per 4 cycles; FIFO absorbs bursts up to DEPTH.
REQ-021 Push and pop on the same edge SHALL both take effect; occupancy unchanged.
REQ-022 Full: cmd_ready=0, no write; empty: no pop, FSM stays IDLE.
REQ-023 ovf_count SHALL increment in CAPTURE when ALU Overflow=1, saturating at 255.
REQ-024 flush SHALL on that edge empty FIFO, clear rsp_valid, return FSM to IDLE; tag counter and ovf_count retained; a cmd handshake in that cycle is discarded.
REQ-025 ALU contract: ADD X=A+B (8-bit), Y=0, Overflow=signed overflow, Carry=unsigned carry-out; MUL {X,Y}=A*B signed 16-bit; AND/XOR X=A op B, Y=0, flags 0.

Reset
REQ-026 rst_n low SHALL immediately clear FIFO pointers/count, FSM=IDLE, instr_q=0, rsp_valid=0, rsp_x=rsp_y=0, rsp_ovf=rsp_carry=0, rsp_tag=0, tag counter=0, ovf_count=0.
REQ-027 cmd_ready SHALL be 0 during reset and 1 from the first edge after release.
REQ-028 Reset mid-operation SHALL discard in-flight instruction and pending response with no partial output.

Structure
REQ-029 Shared package SHALL hold opcode constants (OP_ADD..OP_XOR), FSM state encoding, instruction width 18.
REQ-030 SHALL instantiate alu8bit as the single sub-module, driven only by instr_q.
REQ-031 FIFO SHALL be inline register array with DEPTH entries, log2(DEPTH)+1-bit count.

Verification
REQ-032 ADD 33+7, rsp_ready=1 -> rsp_x=40, rsp_y=0, ovf=0, carry=0, rsp_tag=0, 3 cycles after accept.
REQ-033 ADD 119+57 -> rsp_x=-80, ovf=1, carry=0; ovf_count=1.
REQ-034 MUL 17*-11 -> rsp_x=0xFF, rsp_y=0x45; MUL 3*29 -> rsp_x=0, rsp_y=87.
REQ-035 Burst 5 cmds (AND 23,15; XOR 9,47; ...) with rsp_ready=0 -> cmd_ready drops after DEPTH+1 accepts; first rsp holds X=7 stable; release -> all in order, tags 0,1,2,3,0.
REQ-036 flush while rsp_valid=1 with 2 queued -> rsp_valid=0 next cycle, no further responses, tag continues from prior value.
REQ-037 rst_n pulsed low asynchronously in CAPTURE -> all outputs zero immediately, no response after release.
